// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
//   Instruction fetch stage. Owns the fetch PC, keeps one word request
//   outstanding to instruction memory at a time, buffers returned words in a
//   DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
//   A redirect flushes the buffer and restarts fetch at the new target. If the
//   redirect catches a request that has not yet been acknowledged, that
//   request is finished first (DRAIN) and its data is dropped.
//
// Parameters
//   RESET_PC     word-aligned fetch address after reset
//   DEPTH        instruction buffer entries (2..8)
// Ports (bit 0 is the MSB on all 32-bit buses)
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   imem_req     registered memory request, held until imem_ack
//   imem_addr    request word address, bits [30:31] always 0
//   imem_ack     request accepted, imem_data valid in the same cycle
//   imem_data    returned instruction word
//   instr        buffer head instruction
//   instr_pc     address of instr
//   instr_valid  buffer not empty
//   instr_ready  decode takes the head this cycle
//   redirect     control-flow change (pulse or held)
//   redirect_pc  new fetch address, low two bits ignored
module fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_data,
  output logic [0:31] instr,
  output logic [0:31] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [0:31] redirect_pc
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
  localparam logic [0:31]   ALIGN_M = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          req_q, req_nxt;
  logic [0:31]   addr_q, addr_nxt;
  logic [0:31]   tgt_q, tgt_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] wr_ptr, wr_nxt;
  logic [PW-1:0] rd_ptr, rd_nxt;

  logic [0:31]   data_mem [DEPTH];
  logic [0:31]   pc_mem   [DEPTH];

  logic          acc;
  logic          pop;
  logic          push;
  logic [0:31]   rtgt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // ---- next-state / request control ----
  always_comb begin
    acc       = req_q & imem_ack;
    pop       = instr_valid & instr_ready;
    rtgt      = redirect_pc & ALIGN_M;
    push      = 1'b0;
    state_nxt = state;
    addr_nxt  = addr_q;
    tgt_nxt   = tgt_q;
    count_nxt = count;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;

    if (redirect) begin
      // Redirect wins over push, pop and the full decision; a word acked on
      // this edge belongs to the abandoned stream and is dropped.
      count_nxt = '0;
      wr_nxt    = '0;
      rd_nxt    = '0;
      tgt_nxt   = rtgt;
      case (state)
        REQ: begin
          if (acc) begin
            addr_nxt = rtgt;
          end else begin
            // imem_addr must not move until the pending request completes.
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          if (acc) begin
            state_nxt = REQ;
            addr_nxt  = rtgt;
          end
        end
        default: begin
          state_nxt = REQ;
          addr_nxt  = rtgt;
        end
      endcase
    end else begin
      if (pop) begin
        rd_nxt = ptr_inc(rd_ptr);
      end
      case (state)
        REQ: begin
          if (acc) begin
            push     = 1'b1;
            wr_nxt   = ptr_inc(wr_ptr);
            addr_nxt = addr_q + 32'd4;
          end
        end
        DRAIN: begin
          if (acc) begin
            state_nxt = REQ;
            addr_nxt  = tgt_q;
          end
        end
        IDLE: begin
        end
        default: begin
          state_nxt = REQ;
        end
      endcase
      count_nxt = count + CW'(push) - CW'(pop);
      // Only issue another request when the word it returns is sure to fit.
      if ((state == REQ) && acc) begin
        state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
      end
      if ((state == IDLE) && (count_nxt < DEPTH_C)) begin
        state_nxt = REQ;
      end
    end

    req_nxt = (state_nxt != IDLE);
  end

  // ---- control registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= REQ;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
      tgt_q  <= RESET_PC;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      req_q  <= req_nxt;
      addr_q <= addr_nxt;
      tgt_q  <= tgt_nxt;
      count  <= count_nxt;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
    end
  end

  // ---- instruction buffer storage ----
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]   <= addr_q;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count != '0);
  // Empty buffer presents zeros so stale entries never leak out after a flush.
  assign instr       = instr_valid ? data_mem[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (count < DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam int          SEG    = 48;

  logic        clk         = 1'b0;
  logic        reset_n     = 1'b1;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack    = 1'b0;
  logic [0:31] imem_data;
  logic [0:31] instr;
  logic [0:31] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect    = 1'b0;
  logic [0:31] redirect_pc = '0;

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: after reset or a redirect, decode must see consecutive
  // words starting at the (aligned) target, each equal to the memory word.
  typedef struct {
    int          epoch;
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   epoch_s = 0;

  task automatic push_seg(input logic [31:0] base);
    exp_t e;
    epoch_s++;
    for (int i = 0; i < SEG; i++) begin
      e.epoch = epoch_s;
      e.pc    = base + 32'(4 * i);
      e.word  = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Instruction memory: ack after a configurable number of wait cycles.
  bit ack_hi   = 1'b1;
  bit lat_rand = 1'b0;
  int lat_cfg  = 0;
  int cur_lat  = 0;
  int wcnt     = 0;
  bit pend_acc = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (pend_acc || imem_req !== 1'b1) begin
        wcnt    = 0;
        cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      imem_ack = (imem_req === 1'b1) && (ack_hi || wcnt >= cur_lat);
      pend_acc = imem_ack;
      if (imem_req === 1'b1 && !imem_ack) wcnt++;
    end
  end

  int rst_seen = 0;
  initial forever begin
    @(negedge reset_n);
    rst_seen++;
  end

  // Monitor / scoreboard, sampled 3 time units after the falling edge.
  bit          mon_en    = 1'b0;
  int          mon_epoch = 0;
  int          rst_prev  = 0;
  bit          prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  bit          after_red = 1'b0;
  int          pops      = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_seen != rst_prev) begin
        rst_prev  = rst_seen;
        mon_epoch++;
        prev_pend = 1'b0;
        after_red = 1'b0;
      end
      if (mon_en && reset_n) begin
        if (after_red) check("valid_after_redirect", 32'(instr_valid), 0);
        after_red = 1'b0;
        if (imem_req) check("addr_aligned", imem_addr & 32'h3, 0);
        if (prev_pend) begin
          check("req_held", 32'(imem_req), 1);
          check("addr_held", imem_addr, prev_addr);
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (instr_valid && instr_ready) begin
          while (exp_q.size() > 0 && exp_q[0].epoch < mon_epoch) void'(exp_q.pop_front());
          if (exp_q.size() == 0 || exp_q[0].epoch != mon_epoch) begin
            check("scoreboard_has_entry", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("stream_pc", instr_pc, e.pc);
            check("stream_instr", instr, e.word);
            pops++;
          end
        end
        if (redirect) begin
          mon_epoch++;
          after_red = 1'b1;
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse inside one cycle; ends one cycle later.
  task automatic do_reset();
    push_seg(RST_PC);
    reset_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_addr", imem_addr, RST_PC);
    #2;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc();
  endtask

  task automatic redir(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    push_seg(t & 32'hFFFF_FFFC);
    cyc();
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int nreq;
    int since;
    int r;
    int pops_start;
    logic [31:0] seen;

    cyc();

    // Reset and streaming with ack tied high and decode always ready.
    instr_ready = 1'b1;
    ack_hi = 1'b1;
    lat_rand = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check("stream_req", 32'(imem_req), 1);
      check("stream_addr", imem_addr, RST_PC + 32'(4 * i));
      if (i == 0) begin
        check("stream_first_valid", 32'(instr_valid), 0);
      end else begin
        check("stream_valid", 32'(instr_valid), 1);
        check("stream_lag_pc", instr_pc, RST_PC + 32'(4 * (i - 1)));
        check("stream_word", instr, mem_word(RST_PC + 32'(4 * (i - 1))));
      end
      cyc();
    end

    // Redirect with same-cycle ack and pop.
    redir(32'h0000_0500);
    check("sc_valid_low", 32'(instr_valid), 0);
    check("sc_req", 32'(imem_req), 1);
    check("sc_addr", imem_addr, 32'h0000_0500);
    cyc();
    check("sc_first_pc", instr_pc, 32'h0000_0500);
    check("sc_first_word", instr, mem_word(32'h0000_0500));
    check("sc_next_addr", imem_addr, 32'h0000_0504);

    // Wrap past the top of the address space (unaligned target).
    redir(32'hFFFF_FFFE);
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc();
    check("wrap_addr_zero", imem_addr, 32'h0000_0000);
    check("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc_zero", instr_pc, 32'h0000_0000);

    // Backpressure: buffer fills, request drops, one slot frees one request.
    instr_ready = 1'b0;
    do_reset();
    cyc();
    cyc();
    check("bp_req_dropped", 32'(imem_req), 0);
    check("bp_valid", 32'(instr_valid), 1);
    check("bp_head_pc", instr_pc, RST_PC);
    check("bp_head_word", instr, mem_word(RST_PC));
    cyc();
    check("bp_req_still_low", 32'(imem_req), 0);
    check("bp_head_pc_hold", instr_pc, RST_PC);
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    check("bp_one_req_addr", imem_addr, RST_PC + 32'h8);
    check("bp_next_head", instr_pc, RST_PC + 32'h4);
    nreq = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) nreq++;
      cyc();
    end
    check("bp_exactly_one_req", 32'(nreq), 1);

    // Redirect while a request waits: the pending request drains first.
    instr_ready = 1'b1;
    ack_hi = 1'b0;
    lat_cfg = 3;
    do_reset();
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (imem_req && imem_addr == 32'h0000_0104) begin ok = 1'b1; break; end
      cyc();
    end
    check("dw_wait_req_104", 32'(ok), 1);
    cyc();
    redir(32'h0000_2003);
    check("dw_addr_hold", imem_addr, 32'h0000_0104);
    check("dw_req_hold", 32'(imem_req), 1);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_addr != 32'h0000_0104) begin ok = 1'b1; break; end
      check("dw_no_valid_in_drain", 32'(instr_valid), 0);
      cyc();
    end
    check("dw_wait_addr_change", 32'(ok), 1);
    check("dw_target_addr", imem_addr, 32'h0000_2000);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      cyc();
    end
    check("dw_wait_valid", 32'(ok), 1);
    check("dw_first_pc", instr_pc, 32'h0000_2000);

    // Two redirects before the drained request completes.
    do_reset();
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (imem_req && imem_addr == 32'h0000_0104) begin ok = 1'b1; break; end
      cyc();
    end
    check("dd_wait_req_104", 32'(ok), 1);
    cyc();
    redir(32'h0000_0300);
    redir(32'h0000_0400);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_addr != 32'h0000_0104) begin ok = 1'b1; break; end
      cyc();
    end
    check("dd_wait_addr_change", 32'(ok), 1);
    check("dd_target_addr", imem_addr, 32'h0000_0400);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      cyc();
    end
    check("dd_wait_valid", 32'(ok), 1);
    check("dd_first_pc", instr_pc, 32'h0000_0400);

    // Asynchronous reset while a request is pending and the buffer is full.
    instr_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (instr_valid && imem_req) begin ok = 1'b1; break; end
      cyc();
    end
    check("ar_wait_busy", 32'(ok), 1);
    do_reset();
    check("ar_restart_req", 32'(imem_req), 1);
    check("ar_restart_addr", imem_addr, RST_PC);
    instr_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (instr_valid) begin ok = 1'b1; break; end
      cyc();
    end
    check("ar_wait_valid", 32'(ok), 1);
    check("ar_first_pc", instr_pc, RST_PC);

    // Randomized traffic: variable latency, ready, redirects and resets.
    lat_rand = 1'b1;
    ack_hi = 1'b0;
    since = 0;
    pops_start = pops;
    for (int c = 0; c < 1500; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        do_reset();
        since = 0;
      end else if (r < 10 || since >= 40) begin
        seen = $urandom;
        if (r == 1) seen = seen | 32'hFFFF_FFF0;
        redir(seen);
        since = 0;
      end else begin
        cyc();
        since++;
      end
    end
    redirect = 1'b0;
    check("random_progress", 32'((pops - pops_start) > 100), 1);

    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the 32-bit instruction stream consumed by the control decoder. It owns the fetch PC and issues word requests to instruction memory with one request outstanding at a time. Returned words are buffered in a small FIFO and presented to decode over a valid/ready handshake. Taken branch, jump and register-jump targets from downstream arrive as a redirect, which flushes the buffer and restarts fetch.

## Interface
- RESET_PC, 32'h00000000: fetch address after reset. Must be word-aligned.
- DEPTH, 2: instruction buffer entries (2..8).
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  memory request; held until accepted.
- imem_addr  out  [0:31]  word address; bit 0 is the MSB; bits [30:31] are always 0.
- imem_ack  in  1  request accepted, with data valid this cycle. Meaningful only while imem_req=1.
- imem_data  in  [0:31]  instruction word; sampled on the edge where imem_req & imem_ack.
- instr  out  [0:31]  buffer head instruction (opcode in [0:5]).
- instr_pc  out  [0:31]  address of instr; used downstream for PCtoReg and branch targets.
- instr_valid  out  1  buffer not empty.
- instr_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  control-flow change; single-cycle pulse or held.
- redirect_pc  in  [0:31]  new fetch address; bits [30:31] are forced to 0 internally.

## Operation
- State machine with states IDLE, REQ and DRAIN. Reset state is REQ.
- **REQ:** imem_req=1 and imem_addr=fpc. On the edge where ack occurs:
  - push {imem_data, fpc};
  - fpc <= fpc+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0;
  - next state is REQ if (count after this edge) < DEPTH, else IDLE.
  - With no ack, imem_addr is held stable.
- **IDLE:** imem_req=0. Go to REQ on the first edge after which count < DEPTH.
- **DRAIN:** imem_req=1 and imem_addr holds the abandoned address. On ack:
  - discard the data with no push;
  - go to REQ with fpc = the latched redirect target.
- Pop occurs when instr_valid & instr_ready. Push and pop on the same edge leaves count unchanged. Data is FIFO ordered.
- Redirect sampled on an edge:
  - FIFO is flushed (count=0). A pop on the same edge is discarded; the consumer already took it.
  - fpc/target <= redirect_pc & ~3.
  - From REQ with no ack on that edge: go to DRAIN, because the transaction must complete before imem_addr changes.
  - From REQ with ack on the same edge: the returned data is discarded and the next state is REQ at the target. No DRAIN is needed.
  - From IDLE: go to REQ at the target.
  - From DRAIN: the target is overwritten by the newest redirect_pc. Stay in DRAIN unless ack occurs on the same edge, in which case go to REQ at the new target.
- Redirect has priority over push, pop and the FIFO-full decision.
- Because a request is only issued when count < DEPTH, an ack never finds the FIFO full. If that invariant is violated, it is an assertion failure.

## Timing
- Reset (asynchronous, immediate) sets:
  - imem_req=0 and imem_addr=RESET_PC;
  - instr_valid=0, instr=0, instr_pc=0;
  - count=0, fpc=RESET_PC, state=REQ.
- The first imem_req=1 is driven the cycle after reset_n rises.
- Reset asserted mid-transaction abandons the request. Instruction memory must tolerate a dropped imem_req.
- imem_req is a registered output with no combinational path from imem_ack. Outputs instr, instr_pc and instr_valid come from registers only, with no combinational path from imem_data or redirect.
- Latency: ack on edge N gives instr_valid=1 in cycle N+1 when the FIFO was empty.
- Throughput: with imem_ack tied high and instr_ready=1, one instruction is delivered per cycle after a 2-cycle startup.
- Redirect on edge N, no outstanding drain, same-cycle memory ack: the request to the target is driven in cycle N+1 and the first target instruction is valid in cycle N+2.
- After a redirect, instr_valid=0 in cycle N+1.

## Test plan
- **Reset and stream:** RESET_PC=0x100, ack tied 1, ready=1. Expect:
  - imem_addr 0x100, 0x104, 0x108, … on consecutive cycles;
  - instr_pc follows with 1-cycle lag;
  - instr equals the memory model word.
- **Backpressure:** DEPTH=2, ready=0. After 2 acks, imem_req drops (IDLE) and instr stays at the 0x100 word. When ready rises for one cycle, exactly one new request is issued, to 0x108.
- **Redirect during wait:** ack latency 3, redirect to 0x2003 one cycle after a request to 0x104. Expect:
  - imem_addr holds 0x104 until ack, and that data is never presented;
  - next imem_addr is 0x2000;
  - first valid instr_pc is 0x2000.
- **Redirect with same-cycle ack and pop:** the word being acked is discarded, the FIFO is empty the next cycle, and the next request is to the target.
- **Double redirect in DRAIN:** redirects to 0x300 then 0x400 before ack. Only 0x400 is fetched.
- **Wrap and async reset:**
  - redirect to 0xFFFFFFFC: the next address is 0x00000000;
  - reset_n pulsed low mid-REQ for less than one cycle: imem_req and instr_valid fall immediately, and fetch restarts at RESET_PC.
